execute_muldiv_iter: RTL and testbench
======================================

Name: execute_muldiv_iter

Overview:
Multi-cycle iterative RV64M multiply/divide unit beside the single-cycle execute ALU. The ALU hands off all M-extension ops, including the W forms, and this block returns the result later via a valid/ready handshake. It replaces wide combinational multipliers and dividers with a radix-2 shift-add / restoring-divide datapath. Width and tag size are parametrised, and a flush input supports pipeline redirect.

Parameters:
WIDTH, 64, datapath width; legal values 32 or 64 (if 32, in_word is ignored and treated as 0)
TAG_W, 5, width of the sideband tag carried with each op (destination register index)

Ports:
clk  input  1  clock, all state updates on rising edge
rst_n  input  1  asynchronous active-low reset
flush  input  1  synchronous kill of the in-flight op
in_valid  input  1  request valid
in_ready  output  1  unit can accept a request
in_op  input  3  0 MUL, 1 MULH, 2 MULHSU, 3 MULHU, 4 DIV, 5 DIVU, 6 REM, 7 REMU
in_word  input  1  W variant (MULW/DIVW/DIVUW/REMW/REMUW); ignored for in_op 1-3
in_src1  input  WIDTH  rs1 value
in_src2  input  WIDTH  rs2 value
in_tag  input  TAG_W  sideband, returned unchanged
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
out_result  output  WIDTH  result
out_tag  output  TAG_W  tag of the op that produced out_result

Behaviour:
- Reset (rst_n low, async): state IDLE, in_ready=1, out_valid=0, out_result=0, out_tag=0, counter=0. Reset mid-op discards the op.
- States: IDLE, CALC, FIX, DONE. in_ready = (state==IDLE). No overlap: the next op is accepted only after the previous result handshake.
- IDLE: on in_valid, latch op, word, tag and operands.
  - Special case (divide op with divisor 0, or signed overflow): go to FIX with the result preloaded.
  - Otherwise go to CALC with counter=N, where N=32 for word ops and N=WIDTH otherwise.
- Word operand prep: use bits [31:0]. Signed ops (MULW, DIVW, REMW) sign-extend from bit 31; DIVUW/REMUW zero-extend.
- CALC: one iteration per cycle on operand magnitudes; counter decrements. When counter reaches 1 the next edge moves to FIX.
  - Multiply: shift-add, 2N-bit product.
  - Divide: restoring, one quotient bit per cycle, remainder kept.
- FIX (1 cycle):
  - Apply sign correction. MULH: signed×signed. MULHSU: signed src1 × unsigned src2. DIV/REM: quotient is negative iff operand signs differ; remainder takes the dividend's sign.
  - Select the low or high half.
  - Word ops: result = sign-extend of bit 31 of the 32-bit result, including DIVUW/REMUW.
  - Register into out_result and out_tag, then go to DONE.
- DONE: out_valid=1, out_result/out_tag held stable. On out_ready go to IDLE, with out_valid=0 the next cycle.
- Latency, counted in edges after the accept edge until out_valid is seen high:
  - Normal ops: N+1 (65 for 64-bit ops, 33 for word ops).
  - Special cases: 1.
- Special results:
  - Divide by zero: quotient = all ones; remainder = dividend (word: sign-extended src1[31:0]).
  - Signed overflow (most-negative / −1): quotient = dividend; remainder = 0. Word form detects 0x80000000 / 0xFFFFFFFF on the low 32 bits.
- flush: highest priority over every other transition. The next edge forces IDLE and out_valid=0; the result is discarded. An in_valid in the same cycle as flush is not accepted.
- out_result and out_tag change only on the FIX→DONE transition or reset.

Test Plan:
- MUL 7×(−3), WIDTH=64: accept, out_valid after 65 edges, out_result=0xFFFFFFFFFFFFFFEB, out_tag echoed.
- MULHU 0xFFFFFFFFFFFFFFFF×0xFFFFFFFFFFFFFFFF → 0xFFFFFFFFFFFFFFFE. MULHSU −1×2 → 0xFFFFFFFFFFFFFFFF. MULH −1×−1 → 0.
- DIV 20/0 → 0xFFFFFFFFFFFFFFFF after 1 edge. REM 20/0 → 20. DIV 0x8000000000000000/−1 → 0x8000000000000000. REM of the same → 0.
- DIVW 0x0000000180000000/0xFFFFFFFF → 0xFFFFFFFF80000000. DIVUW 0x80000000/1 → 0xFFFFFFFF80000000, 33-edge latency. REMW −7/2 → 0xFFFFFFFFFFFFFFFF.
- Backpressure: hold out_ready=0 for 10 cycles in DONE. out_valid and out_result stay stable and in_ready=0. Raise out_ready: IDLE next cycle, and a second op is accepted.
- Flush at CALC counter=30: IDLE next edge, no out_valid. A new op then completes correctly. Asserting rst_n=0 mid-CALC gives all outputs at reset values immediately.

Source files
------------

// File: rtl/execute_muldiv_iter.sv
// ---------------------------------------------------------------------------
// execute_muldiv_iter
// Iterative RV64M multiply/divide unit. It takes one M-extension op at a time
// from the execute stage and returns the result through a valid/ready
// handshake. Multiplies use radix-2 shift-add and divides use a restoring
// divider, one bit per cycle, both on operand magnitudes. A fix-up cycle then
// applies the sign and selects the half or word that the op asks for.
//
// Ports
//   clk, rst_n          clock, asynchronous active-low reset
//   flush               kills the in-flight op on the next edge
//   in_valid/in_ready   request handshake (in_ready only in IDLE)
//   in_op, in_word      op select (MUL..REMU) and W-form select
//   in_src1, in_src2    rs1 / rs2 operands
//   in_tag              sideband tag returned with the result
//   out_valid/out_ready result handshake
//   out_result, out_tag registered result and its tag
// ---------------------------------------------------------------------------
module execute_muldiv_iter #(
   parameter int WIDTH = 64,
   parameter int TAG_W = 5
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [2:0]       in_op,
   input  logic             in_word,
   input  logic [WIDTH-1:0] in_src1,
   input  logic [WIDTH-1:0] in_src2,
   input  logic [TAG_W-1:0] in_tag,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic [TAG_W-1:0] out_tag
);

   localparam int CW = $clog2(WIDTH) + 1;
   localparam logic [WIDTH-1:0] ZERO_W = {WIDTH{1'b0}};
   localparam logic [WIDTH-1:0] ONES_W = {WIDTH{1'b1}};
   localparam logic [WIDTH-1:0] MIN_W  = {1'b1, {(WIDTH-1){1'b0}}};

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_FIX  = 2'd2,
      S_DONE = 2'd3
   } state_t;

   state_t           state_q, state_d;
   logic [CW-1:0]    cnt_q, cnt_d;
   logic [2:0]       op_q, op_d;
   logic             word_q, word_d;
   logic             special_q, special_d;
   logic             neg_q, neg_d;
   logic [WIDTH:0]   acc_q, acc_d;      // product high half / partial remainder
   logic [WIDTH-1:0] lo_q, lo_d;        // multiplier+product low / dividend+quotient
   logic [WIDTH-1:0] b_q, b_d;          // multiplicand / divisor magnitude
   logic [TAG_W-1:0] tag_q, tag_d;
   logic [WIDTH-1:0] res_q, res_d;
   logic [TAG_W-1:0] otag_q, otag_d;

   function automatic logic [WIDTH-1:0] sext32(input logic [31:0] v);
      return WIDTH'($signed(v));
   endfunction

   // ---------------- request decode and operand preparation ----------------
   logic             word_s, a_signed_s, b_signed_s;
   logic [WIDTH-1:0] a_ext_s, b_ext_s, a_mag_s, b_mag_s, dvd_s, spec_s, lo_init_s;
   logic             a_neg_s, b_neg_s, neg_s, dz_s, ovf_s;

   // W forms exist only for MUL and the divide group, and only on a 64-bit datapath
   assign word_s     = (WIDTH == 64) && in_word && ((in_op == 3'd0) || in_op[2]);
   // MUL keeps unsigned operands: the low half of the product is sign-agnostic
   assign a_signed_s = (in_op == 3'd1) || (in_op == 3'd2) || (in_op == 3'd4) || (in_op == 3'd6);
   assign b_signed_s = (in_op == 3'd1) || (in_op == 3'd4) || (in_op == 3'd6);

   assign a_ext_s = !word_s ? in_src1 :
                    (a_signed_s ? sext32(in_src1[31:0]) : WIDTH'(in_src1[31:0]));
   assign b_ext_s = !word_s ? in_src2 :
                    (b_signed_s ? sext32(in_src2[31:0]) : WIDTH'(in_src2[31:0]));

   assign a_neg_s = a_signed_s && a_ext_s[WIDTH-1];
   assign b_neg_s = b_signed_s && b_ext_s[WIDTH-1];
   assign a_mag_s = a_neg_s ? (ZERO_W - a_ext_s) : a_ext_s;
   assign b_mag_s = b_neg_s ? (ZERO_W - b_ext_s) : b_ext_s;
   // remainder follows the dividend alone; all other signed results use the sign xor
   assign neg_s   = (in_op == 3'd6) ? a_neg_s : (a_neg_s ^ b_neg_s);

   assign dz_s  = in_op[2] && (b_ext_s == ZERO_W);
   assign ovf_s = in_op[2] && !in_op[0] &&
                  (word_s ? ((in_src1[31:0] == 32'h8000_0000) && (in_src2[31:0] == 32'hFFFF_FFFF))
                          : ((a_ext_s == MIN_W) && (b_ext_s == ONES_W)));

   // the dividend as returned by the special cases; W forms always sign-extend
   assign dvd_s  = word_s ? sext32(in_src1[31:0]) : in_src1;
   assign spec_s = dz_s ? (in_op[1] ? dvd_s : ONES_W)
                        : (in_op[1] ? ZERO_W : dvd_s);

   // a 32-step divide must see the word dividend MSB-aligned in the shift register
   assign lo_init_s = (in_op[2] && word_s) ? (a_mag_s << (WIDTH - 32)) : a_mag_s;

   // ---------------- iteration datapath ----------------
   logic [WIDTH:0] mul_sum_s, div_sh_s, div_try_s;
   logic           div_q_s;

   assign mul_sum_s = acc_q + (lo_q[0] ? {1'b0, b_q} : {(WIDTH+1){1'b0}});
   assign div_sh_s  = {acc_q[WIDTH-1:0], lo_q[WIDTH-1]};
   assign div_q_s   = (div_sh_s >= {1'b0, b_q});
   assign div_try_s = div_sh_s - {1'b0, b_q};

   // ---------------- fix-up: sign correction and half/word select ----------------
   logic [WIDTH-1:0] mulh_s, quo_s, rem_s, fix_s;

   // high half of the negated 2N-bit product: invert, plus carry out of the low half
   assign mulh_s = neg_q ? (~acc_q[WIDTH-1:0] + WIDTH'(lo_q == ZERO_W)) : acc_q[WIDTH-1:0];
   assign quo_s  = neg_q ? (ZERO_W - lo_q) : lo_q;
   assign rem_s  = neg_q ? (ZERO_W - acc_q[WIDTH-1:0]) : acc_q[WIDTH-1:0];

   // final result select for the FIX cycle
   always_comb begin
      fix_s = lo_q;
      if (special_q) begin
         fix_s = lo_q;
      end else begin
         case (op_q)
            // a 32-step word multiply leaves its low product word in lo_q's top half
            3'd0:          fix_s = word_q ? sext32(lo_q[WIDTH-1 -: 32]) : lo_q;
            3'd1, 3'd2,
            3'd3:          fix_s = mulh_s;
            3'd4, 3'd5:    fix_s = word_q ? sext32(quo_s[31:0]) : quo_s;
            3'd6, 3'd7:    fix_s = word_q ? sext32(rem_s[31:0]) : rem_s;
            default:       fix_s = lo_q;
         endcase
      end
   end

   // next-state and datapath update
   always_comb begin
      state_d   = state_q;
      cnt_d     = cnt_q;
      op_d      = op_q;
      word_d    = word_q;
      special_d = special_q;
      neg_d     = neg_q;
      acc_d     = acc_q;
      lo_d      = lo_q;
      b_d       = b_q;
      tag_d     = tag_q;
      res_d     = res_q;
      otag_d    = otag_q;
      if (flush) begin
         state_d = S_IDLE;
         cnt_d   = {CW{1'b0}};
      end else begin
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  op_d   = in_op;
                  word_d = word_s;
                  tag_d  = in_tag;
                  neg_d  = neg_s;
                  acc_d  = {(WIDTH+1){1'b0}};
                  if (dz_s || ovf_s) begin
                     special_d = 1'b1;
                     lo_d      = spec_s;
                     b_d       = ZERO_W;
                     cnt_d     = {CW{1'b0}};
                     state_d   = S_FIX;
                  end else begin
                     special_d = 1'b0;
                     lo_d      = lo_init_s;
                     b_d       = b_mag_s;
                     cnt_d     = word_s ? CW'(32) : CW'(WIDTH);
                     state_d   = S_CALC;
                  end
               end else begin
                  state_d = S_IDLE;
               end
            end
            S_CALC: begin
               if (op_q[2]) begin
                  acc_d = div_q_s ? div_try_s : div_sh_s;
                  lo_d  = {lo_q[WIDTH-2:0], div_q_s};
               end else begin
                  acc_d = {1'b0, mul_sum_s[WIDTH:1]};
                  lo_d  = {mul_sum_s[0], lo_q[WIDTH-1:1]};
               end
               cnt_d = cnt_q - CW'(1);
               if (cnt_q == CW'(1)) begin
                  state_d = S_FIX;
               end else begin
                  state_d = S_CALC;
               end
            end
            S_FIX: begin
               res_d     = fix_s;
               otag_d    = tag_q;
               special_d = 1'b0;
               state_d   = S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  state_d = S_IDLE;
               end else begin
                  state_d = S_DONE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   // state and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         cnt_q     <= {CW{1'b0}};
         op_q      <= 3'd0;
         word_q    <= 1'b0;
         special_q <= 1'b0;
         neg_q     <= 1'b0;
         acc_q     <= {(WIDTH+1){1'b0}};
         lo_q      <= ZERO_W;
         b_q       <= ZERO_W;
         tag_q     <= {TAG_W{1'b0}};
         res_q     <= ZERO_W;
         otag_q    <= {TAG_W{1'b0}};
      end else begin
         state_q   <= state_d;
         cnt_q     <= cnt_d;
         op_q      <= op_d;
         word_q    <= word_d;
         special_q <= special_d;
         neg_q     <= neg_d;
         acc_q     <= acc_d;
         lo_q      <= lo_d;
         b_q       <= b_d;
         tag_q     <= tag_d;
         res_q     <= res_d;
         otag_q    <= otag_d;
      end
   end

   assign in_ready   = (state_q == S_IDLE);
   assign out_valid  = (state_q == S_DONE);
   assign out_result = res_q;
   assign out_tag    = otag_q;

endmodule

// File: tb/tb_execute_muldiv_iter.sv
// ---------------------------------------------------------------------------
// tb_execute_muldiv_iter
// Directed bench for execute_muldiv_iter (WIDTH=64, TAG_W=5). Each vector
// carries a hand-computed result and latency. Also covers backpressure,
// flush mid-calculation, flush with a simultaneous request, and async reset
// mid-calculation.
// ---------------------------------------------------------------------------
module tb_execute_muldiv_iter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        flush;
   logic        in_valid;
   logic        in_ready;
   logic [2:0]  in_op;
   logic        in_word;
   logic [63:0] in_src1;
   logic [63:0] in_src2;
   logic [4:0]  in_tag;
   logic        out_valid;
   logic        out_ready;
   logic [63:0] out_result;
   logic [4:0]  out_tag;

   int n_checks = 0;
   int n_fail   = 0;

   always #5 clk = ~clk;

   execute_muldiv_iter #(.WIDTH(64), .TAG_W(5)) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .flush      (flush),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .in_op      (in_op),
      .in_word    (in_word),
      .in_src1    (in_src1),
      .in_src2    (in_src2),
      .in_tag     (in_tag),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .out_result (out_result),
      .out_tag    (out_tag)
   );

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%h expected 0x%h", tag, obs, exp);
      end
   endtask

   // present one request for exactly one edge (in_ready expected high)
   task automatic issue(input logic [2:0] op, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] tag);
      in_valid = 1'b1;
      in_op    = op;
      in_word  = w;
      in_src1  = a;
      in_src2  = b;
      in_tag   = tag;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
   endtask

   // edges from the accept edge until out_valid is seen, bounded
   task automatic wait_valid(output int lat);
      lat = 0;
      while (out_valid !== 1'b1 && lat < 200) begin
         @(posedge clk);
         #1;
         lat++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] op, input logic w,
                         input logic [63:0] a, input logic [63:0] b, input logic [4:0] tag,
                         input int exp_lat, input logic [63:0] exp_res, input int hold);
      int lat;
      check_eq({name, "_ready_before"}, {63'd0, in_ready}, 64'd1);
      issue(op, w, a, b, tag);
      check_eq({name, "_busy"}, {63'd0, in_ready}, 64'd0);
      wait_valid(lat);
      check_eq({name, "_latency"}, 64'(lat), 64'(exp_lat));
      check_eq({name, "_result"}, out_result, exp_res);
      check_eq({name, "_tag"}, {59'd0, out_tag}, {59'd0, tag});
      for (int i = 0; i < hold; i++) begin
         @(posedge clk);
         #1;
         check_eq({name, "_hold_valid"}, {63'd0, out_valid}, 64'd1);
         check_eq({name, "_hold_result"}, out_result, exp_res);
         check_eq({name, "_hold_ready"}, {63'd0, in_ready}, 64'd0);
      end
      out_ready = 1'b1;
      @(posedge clk);
      #1;
      out_ready = 1'b0;
      check_eq({name, "_valid_drop"}, {63'd0, out_valid}, 64'd0);
      check_eq({name, "_ready_after"}, {63'd0, in_ready}, 64'd1);
   endtask

   initial begin
      int seen;
      rst_n     = 1'b0;
      flush     = 1'b0;
      in_valid  = 1'b0;
      in_op     = 3'd0;
      in_word   = 1'b0;
      in_src1   = 64'd0;
      in_src2   = 64'd0;
      in_tag    = 5'd0;
      out_ready = 1'b0;
      #1;
      check_eq("rst_in_ready", {63'd0, in_ready}, 64'd1);
      check_eq("rst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("rst_out_result", out_result, 64'd0);
      check_eq("rst_out_tag", {59'd0, out_tag}, 64'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // multiplies
      run_op("mul",    3'd0, 1'b0, 64'd7, 64'hFFFF_FFFF_FFFF_FFFD, 5'd5, 65, 64'hFFFF_FFFF_FFFF_FFEB, 0);
      run_op("mulhu",  3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd6, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_op("mulhsu", 3'd2, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd2, 5'd7, 65, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("mulh",   3'd1, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 5'd8, 65, 64'd0, 0);
      run_op("mulw",   3'd0, 1'b1, 64'h1234_5678_7FFF_FFFF, 64'd2, 5'd9, 33, 64'hFFFF_FFFF_FFFF_FFFE, 0);
      run_op("mulhu_w_ignored", 3'd3, 1'b1, 64'h0000_0001_0000_0000, 64'h0000_0001_0000_0000, 5'd10, 65, 64'd1, 0);

      // divide special cases
      run_op("div_by0",   3'd4, 1'b0, 64'd20, 64'd0, 5'd11, 1, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("rem_by0",   3'd6, 1'b0, 64'd20, 64'd0, 5'd12, 1, 64'd20, 0);
      run_op("div_ovf",   3'd4, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd13, 1, 64'h8000_0000_0000_0000, 0);
      run_op("rem_ovf",   3'd6, 1'b0, 64'h8000_0000_0000_0000, 64'hFFFF_FFFF_FFFF_FFFF, 5'd14, 1, 64'd0, 0);
      run_op("divw_ovf",  3'd4, 1'b1, 64'h0000_0001_8000_0000, 64'h0000_0000_FFFF_FFFF, 5'd15, 1, 64'hFFFF_FFFF_8000_0000, 0);
      run_op("remuw_by0", 3'd7, 1'b1, 64'hFFFF_FFFF_0000_0005, 64'hABCD_0000_0000_0000, 5'd16, 1, 64'd5, 0);

      // iterative divides
      run_op("divuw", 3'd5, 1'b1, 64'h0000_0000_8000_0000, 64'd1, 5'd17, 33, 64'hFFFF_FFFF_8000_0000, 0);
      run_op("remw",  3'd6, 1'b1, 64'hFFFF_FFFF_FFFF_FFF9, 64'd2, 5'd18, 33, 64'hFFFF_FFFF_FFFF_FFFF, 0);
      run_op("divu",  3'd5, 1'b0, 64'd100, 64'd7, 5'd19, 65, 64'd14, 0);
      run_op("remu",  3'd7, 1'b0, 64'd100, 64'd7, 5'd20, 65, 64'd2, 0);
      run_op("div_neg", 3'd4, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd21, 65, 64'hFFFF_FFFF_FFFF_FFF2, 0);
      run_op("rem_neg", 3'd6, 1'b0, 64'hFFFF_FFFF_FFFF_FF9C, 64'd7, 5'd22, 65, 64'hFFFF_FFFF_FFFF_FFFE, 0);

      // backpressure: 10 cycles held in DONE, then a second op
      run_op("bp_first",  3'd5, 1'b1, 64'd45, 64'd6, 5'd23, 33, 64'd7, 10);
      run_op("bp_second", 3'd0, 1'b0, 64'd12, 64'd12, 5'd24, 65, 64'd144, 0);

      // flush at counter=30: 64 after the accept edge, 34 edges later it is 30
      issue(3'd5, 1'b0, 64'd1000, 64'd3, 5'd25);
      repeat (34) @(posedge clk);
      #1;
      flush = 1'b1;
      @(posedge clk);
      #1;
      flush = 1'b0;
      check_eq("flush_ready", {63'd0, in_ready}, 64'd1);
      check_eq("flush_valid", {63'd0, out_valid}, 64'd0);
      seen = 0;
      repeat (70) begin
         @(posedge clk);
         #1;
         if (out_valid === 1'b1) seen++;
      end
      check_eq("flush_no_result", 64'(seen), 64'd0);

      // a request together with flush is not accepted
      in_valid = 1'b1;
      flush    = 1'b1;
      in_op    = 3'd4;
      in_word  = 1'b0;
      in_src1  = 64'd9;
      in_src2  = 64'd0;
      in_tag   = 5'd26;
      @(posedge clk);
      #1;
      in_valid = 1'b0;
      flush    = 1'b0;
      check_eq("flush_req_not_taken", {63'd0, in_ready}, 64'd1);
      @(posedge clk);
      #1;
      check_eq("flush_req_no_valid", {63'd0, out_valid}, 64'd0);

      run_op("after_flush", 3'd4, 1'b0, 64'd1000, 64'd3, 5'd27, 65, 64'd333, 0);

      // async reset mid-CALC
      issue(3'd0, 1'b0, 64'd3, 64'd5, 5'd28);
      repeat (10) @(posedge clk);
      #2;
      rst_n = 1'b0;
      #1;
      check_eq("midrst_in_ready", {63'd0, in_ready}, 64'd1);
      check_eq("midrst_out_valid", {63'd0, out_valid}, 64'd0);
      check_eq("midrst_out_result", out_result, 64'd0);
      check_eq("midrst_out_tag", {59'd0, out_tag}, 64'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;
      run_op("after_reset", 3'd3, 1'b0, 64'hFFFF_FFFF_FFFF_FFFF, 64'd16, 5'd29, 65, 64'd15, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
